// File: rtl/ifu.sv
// ifu: instruction fetch unit, one outstanding imem request feeding the ID register; define IFU_SKID_EN for a one-entry stall skid buffer
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        j_flush,
  input  logic [31:0] jppc,
  input  logic        ex_flush,
  input  logic [31:0] ex_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {BOOT, REQ, RESP, HOLD} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, inst_nx, target;
  logic discard, discard_nx, deliver, redir;
`ifdef IFU_SKID_EN
  logic [31:0] skid, skid_nx;
`endif
  // EX redirect wins; a jump resolved in ID is meaningless while ID is frozen
  assign redir = ex_flush | (j_flush & ~stall);
  assign target = (ex_flush ? ex_pc : jppc) & ~32'h3;
  assign imem_req = (state == REQ) && !stall;
  assign imem_addr = pc;
  // next state, next pc and whether an instruction reaches ID this cycle
  always_comb begin
    state_nx = state;
    discard_nx = discard;
    deliver = 1'b0;
    inst_nx = imem_rdata;
`ifdef IFU_SKID_EN
    skid_nx = skid;
`endif
    case (state)
      BOOT: state_nx = REQ;
      REQ: if (imem_req && imem_gnt) begin
        state_nx = RESP;
        discard_nx = redir;
      end
      RESP: if (imem_rvalid) begin
        state_nx = REQ;
        discard_nx = 1'b0;
        deliver = !discard && !redir && !stall;
`ifdef IFU_SKID_EN
        if (!discard && !redir && stall) begin
          state_nx = HOLD;
          skid_nx = imem_rdata;
        end
`endif
      end else if (redir) discard_nx = 1'b1;
`ifdef IFU_SKID_EN
      HOLD: if (redir) state_nx = REQ;
      else if (!stall) begin
        state_nx = REQ;
        deliver = 1'b1;
        inst_nx = skid;
      end
`endif
      default: state_nx = BOOT;
    endcase
    pc_nx = redir ? target : deliver ? pc + 32'd4 : pc;
  end
  // fetch state, pc and discard flag
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= BOOT;
      pc <= RESET_PC & ~32'h3;
      discard <= 1'b0;
`ifdef IFU_SKID_EN
      skid <= 32'h0;
`endif
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      discard <= discard_nx;
`ifdef IFU_SKID_EN
      skid <= skid_nx;
`endif
    end
  // ID register: load on delivery, hold on stall, otherwise a NOP bubble
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      id_valid <= 1'b0;
      id_inst <= NOP;
      id_pc <= 32'h0;
    end else if (redir || (!stall && !deliver)) begin
      id_valid <= 1'b0;
      id_inst <= NOP;
    end else if (deliver) begin
      id_valid <= 1'b1;
      id_inst <= inst_nx;
      id_pc <= pc;
    end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: randomized bench for ifu against a flag-based fetch model and an address-keyed memory
module tb_ifu;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFU_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b1;
  logic stall = 0, j_flush = 0, ex_flush = 0, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] jppc = 0, ex_pc = 0, imem_rdata = 0;
  logic imem_req, id_valid;
  logic [31:0] imem_addr, id_pc, id_inst;
  int n_vec = 0, n_err = 0;
  bit m_boot, m_out, m_stale, m_held, m_vld;
  logic [31:0] m_pc, m_hdata, m_inst, m_idpc;
  bit mem_pend = 0;
  int mem_wait = 0;
  logic [31:0] mem_addr = 0;

  ifu dut (
    .clk(clk), .rstn(rstn), .stall(stall), .j_flush(j_flush), .jppc(jppc),
    .ex_flush(ex_flush), .ex_pc(ex_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0093 : a * 32'h9E37_79B1 + 32'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_id();
    check("id_valid", id_valid, m_vld);
    check("id_inst", id_inst, m_inst);
    check("id_pc", id_pc, m_idpc);
    if (m_vld) check("inst_vs_mem", id_inst, memval(m_idpc));
  endtask

  task automatic do_reset(input bit rv);
    stall = 0; j_flush = 0; ex_flush = 0; imem_gnt = 0;
    imem_rvalid = rv; imem_rdata = 32'hDEAD_BEEF;
    rstn = 1'b0;
    #1;
    m_pc = 32'h8000_0000; m_boot = 1; m_out = 0; m_stale = 0; m_held = 0;
    m_vld = 0; m_inst = NOP; m_idpc = 0;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h8000_0000);
    check_id();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    check_id();
  endtask

  task automatic step(input bit st, input bit jf, input logic [31:0] jp,
                      input bit ef, input logic [31:0] ep, input bit g, input int dly);
    bit redir, dlv, rv, m_req;
    logic [31:0] tgt, dat;
    rv = mem_pend && mem_wait == 0;
    stall = st; j_flush = jf; jppc = jp; ex_flush = ef; ex_pc = ep;
    imem_gnt = g && !mem_pend;
    imem_rvalid = rv;
    imem_rdata = rv ? memval(mem_addr) : $urandom;
    #1;
    m_req = !m_boot && !m_out && !m_held && !st;
    check("imem_req", imem_req, m_req);
    check("imem_addr", imem_addr, m_pc);
    redir = ef || (jf && !st);
    tgt = (ef ? ep : jp) & ~32'h3;
    dlv = 0;
    dat = 0;
    if (m_boot) m_boot = 0;
    else if (m_held) begin
      if (redir) m_held = 0;
      else if (!st) begin dlv = 1; dat = m_hdata; m_held = 0; end
    end else if (m_out) begin
      if (rv) begin
        if (!m_stale && !redir) begin
          if (!st) begin dlv = 1; dat = imem_rdata; end
          else if (SKID) begin m_held = 1; m_hdata = imem_rdata; end
        end
        m_out = 0;
        m_stale = 0;
      end else if (redir) m_stale = 1;
    end else if (m_req && imem_gnt) begin
      m_out = 1;
      m_stale = redir;
    end
    if (mem_pend) begin
      if (mem_wait == 0) mem_pend = 0;
      else mem_wait--;
    end else if (m_req && imem_gnt) begin
      mem_pend = 1; mem_addr = m_pc; mem_wait = dly - 1;
    end
    if (redir || (!st && !dlv)) begin m_vld = 0; m_inst = NOP; end
    else if (dlv) begin m_vld = 1; m_inst = dat; m_idpc = m_pc; end
    m_pc = redir ? tgt : dlv ? m_pc + 32'd4 : m_pc;
    @(posedge clk);
    #1;
    check_id();
  endtask

  task automatic idle(input bit g, input int dly);
    step(0, 0, 0, 0, 0, g, dly);
  endtask

  initial begin
    #3;
    do_reset(0);
    // first fetch sequence out of reset
    idle(0, 1);
    check("boot_addr", imem_addr, 32'h8000_0000);
    idle(1, 1);
    idle(0, 1);
    check("first_pc", id_pc, 32'h8000_0000);
    check("first_valid", id_valid, 1);
    check("first_inst", id_inst, 32'h0000_0093);
    check("second_addr", imem_addr, 32'h8000_0004);
    // jump while a request is outstanding
    idle(1, 3);
    step(0, 1, 32'h8000_0100, 0, 0, 0, 1);
    check("jf_gap0", id_valid, 0);
    idle(0, 1);
    check("jf_gap1", id_valid, 0);
    idle(0, 1);
    check("jf_gap2", id_valid, 0);
    check("jf_addr", imem_addr, 32'h8000_0100);
    idle(1, 1);
    idle(0, 1);
    check("jf_pc", id_pc, 32'h8000_0100);
    // ex_flush beats j_flush
    step(0, 1, 32'h8000_0300, 1, 32'h8000_0200, 0, 1);
    check("prio_addr", imem_addr, 32'h8000_0200);
    // three-cycle stall with the response arriving mid-stall
    idle(1, 2);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    check("stall_addr", imem_addr, 32'h8000_0200);
    check("stall_valid", id_valid, 0);
    idle(0, 1);
    if (!SKID) begin
      idle(1, 1);
      idle(0, 1);
    end
    check("stall_dlv_valid", id_valid, 1);
    check("stall_dlv_pc", id_pc, 32'h8000_0200);
    check("stall_next_addr", imem_addr, 32'h8000_0204);
    // pc wrap with unaligned redirect target
    step(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 1);
    check("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
    idle(1, 1);
    idle(0, 1);
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);
    // reset while a response is outstanding; late rvalid must be ignored
    idle(1, 3);
    idle(0, 1);
    do_reset(1);
    idle(0, 1);
    idle(0, 1);
    check("late_rv_valid", id_valid, 0);
    check("late_rv_inst", id_inst, NOP);
    check("rst_fetch_addr", imem_addr, 32'h8000_0000);
    idle(1, 1);
    idle(0, 1);
    check("rst_fetch_pc", id_pc, 32'h8000_0000);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] jp, ep;
      jp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      ep = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, jp,
           $urandom_range(0, 13) == 0, ep, $urandom_range(0, 4) < 3, $urandom_range(1, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning first fetch address after reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port stall  input  1  load-use hold from ID; ID register frozen.
REQ-005 SHALL have port j_flush  input  1  jump resolved in ID, redirect to jppc.
REQ-006 SHALL have port jppc  input  32  ID jump target.
REQ-007 SHALL have port ex_flush  input  1  branch redirect from EX.
REQ-008 SHALL have port ex_pc  input  32  EX branch target.
REQ-009 SHALL have port imem_req  output  1  fetch request, held until granted.
REQ-010 SHALL have port imem_addr  output  32  fetch address, word aligned.
REQ-011 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-012 SHALL have port imem_rvalid  input  1  response valid, in order, >=1 cycle after grant.
REQ-013 SHALL have port imem_rdata  input  32  returned instruction.
REQ-014 SHALL have port id_pc  output  32  registered PC to ID.
REQ-015 SHALL have port id_inst  output  32  registered instruction to ID.
REQ-016 SHALL have port id_valid  output  1  ID register holds a live instruction.

Function
REQ-017 SHALL implement FSM states BOOT, REQ, RESP, HOLD; reset -> BOOT; BOOT -> REQ after one cycle.
REQ-018 SHALL assert imem_req only in REQ, imem_addr = fetch pc; REQ -> RESP on imem_gnt; at most one request outstanding.
REQ-019 In RESP, on imem_rvalid with stall=0 and no discard: id_inst <= imem_rdata, id_pc <= granted address, id_valid <= 1, pc <= pc+4, state -> REQ; fetch-to-ID latency = grant-to-rvalid + 1 cycle.
REQ-020 While stall=1 (and ex_flush=0), id_pc/id_inst/id_valid SHALL hold; imem_req SHALL stay low in REQ.
REQ-021 In RESP with stall=0 and no rvalid, id_valid SHALL be 0 next cycle (bubble).
REQ-022 Whenever id_valid=0, id_inst SHALL be 32'h0000_0013 (NOP) and id_pc SHALL hold its last value.
REQ-023 Redirect priority: ex_flush > j_flush; j_flush SHALL be ignored while stall=1; ex_flush overrides stall.
REQ-024 On ex_flush: pc <= ex_pc, id_valid <= 0, pending response/buffer discarded, state -> REQ (or RESP-with-discard if a request is outstanding).
REQ-025 On j_flush: pc <= jppc, ID register loads bubble (id_valid <= 0), pending response/buffer discarded.
REQ-026 Redirect in REQ without gnt SHALL change imem_addr next cycle; redirect coincident with gnt SHALL mark that request discarded.
REQ-027 Discarded response SHALL be consumed (rvalid accepted, data dropped) then state -> REQ with redirect pc; rvalid with redirect in same cycle is dropped.
REQ-028 pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0); bits [1:0] of redirect targets forced to 0.

Reset
REQ-029 On rstn=0 asynchronously: state BOOT, pc RESET_PC, imem_req 0, id_valid 0, id_inst 32'h0000_0013, id_pc 0, discard 0, buffer empty.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; a later imem_rvalid before first new grant SHALL be ignored.

Configuration
REQ-031 With IFU_SKID_EN defined: rvalid arriving while stall=1 SHALL be stored in a one-entry buffer (state HOLD) and delivered to ID the first cycle stall=0, no refetch.
REQ-032 Without IFU_SKID_EN: rvalid while stall=1 SHALL be dropped, pc unchanged, state -> REQ, same address refetched after stall drops; HOLD unreachable.

Verification
REQ-033 Reset release, gnt immediate, rvalid 1 cycle later with 32'h00000093 -> imem_addr 32'h8000_0000 then 32'h8000_0004; id_pc=32'h8000_0000, id_valid=1.
REQ-034 j_flush=1, jppc=32'h8000_0100 with request outstanding -> stale rvalid dropped, next imem_addr 32'h8000_0100, id_valid 0 for the gap.
REQ-035 ex_flush and j_flush same cycle, ex_pc=32'h8000_0200 -> next fetch 32'h8000_0200.
REQ-036 stall=1 for 3 cycles during RESP, rvalid mid-stall -> SKID: delivered on stall release, no refetch; no SKID: same address re-requested, then delivered.
REQ-037 rstn low while in RESP, rvalid arrives during/after reset before new gnt -> ignored; first fetch 32'h8000_0000, id_inst 32'h0000_0013.
